gnrc_sdpram_pipe: RTL and testbench
===================================

Name: gnrc_sdpram_pipe

Overview:
Single-clock simple dual-port RAM: one write port, one read port. Adds a parametrised read latency, a read-valid output and selectable same-address collision handling (read-first or write-first bypass) with byte-lane granularity. It sits wherever a same-clock-domain buffer, lookup table or FIFO storage needs a known latency and valid tracking. The storage array remains BRAM-inferable: no reset on the array, and the bypass logic sits outside it.

Parameters:
DW, 32, data bit width (>=1)
DP, 512, RAM depth in words (>=2); need not be a power of two
LATENCY, 1, read latency in cycles from ren_i to rvalid_o (>=1); LATENCY-1 extra pipeline stages follow the array read register
COLLISION, 0, 0 = read-first (old data); 1 = write-first (new data forwarded per byte lane)
BYTE_WRITE, 0, 1 = per-byte write mask
INIT_BY_ZERO, 1, 1 = array initialised to zero at time 0 (initial block, not reset)
AW, $clog2(DP), address width (derived, do not override)
MW, BYTE_WRITE ? ceil(DW/8) : 1, write-mask width (derived, do not override)

Ports:
clk_i  input  1  single clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
wen_i  input  1  write port enable
we_i  input  MW  write mask; lane k covers bits [min(8k+7,DW-1):8k] if BYTE_WRITE, else whole word
waddr_i  input  AW  write address
wdata_i  input  DW  write data
ren_i  input  1  read request
raddr_i  input  AW  read address
rdata_o  output  DW  read data, valid when rvalid_o=1
rvalid_o  output  1  read data valid strobe, one cycle per accepted read

Behaviour:
- Reset (rst_i=1 at clock edge): all valid-pipeline bits cleared; rvalid_o=0; rdata_o=0; all pipeline data registers=0. Array contents untouched. Writes and reads presented in a reset cycle are ignored (no array update, no valid issued).
- Reset mid-operation: in-flight reads are dropped; no rvalid_o for them after reset deasserts.
- Write: at the edge where wen_i=1, rst_i=0 and waddr_i<DP, mem[waddr_i] lane k <= wdata_i lane k for each k with we_i[k]=1. we_i=0 with wen_i=1 is a no-op.
- Read accept: a read is accepted at an edge with ren_i=1 and rst_i=0. Its data appears on rdata_o with rvalid_o=1 exactly LATENCY cycles later (LATENCY=1: the cycle after the request). Back-to-back reads every cycle are supported; throughput is 1 read/cycle.
- rdata_o is held when no valid reaches the output stage. The pipeline data stages load only when their valid bit is set (clock-gating friendly).
- Out of range (waddr_i/raddr_i >= DP, possible only if DP is not a power of two): write ignored; read still accepted and returns all zeros with rvalid_o=1.
- Collision (same edge: accepted write and accepted read, waddr_i==raddr_i, in range):
  - COLLISION=0: returned data = array contents before the write.
  - COLLISION=1: returned lane k = wdata_i lane k if wen_i & we_i[k], else old array lane. Forwarding muxes are registered alongside the read (capture the forward data and per-lane select in the first stage); the array itself stays read-first.
- Writes issued after a read is accepted never alter that read's returned data, for any LATENCY.
- Partial top lane: when DW%8≠0 and BYTE_WRITE=1, lane MW-1 is narrower; mask and forwarding apply to the valid bits only.
- Elaboration: fatal error if LATENCY<1, DP<2, or DW<1.

Test Plan:
- Reset/idle: assert rst_i 3 cycles with ren_i=1, wen_i=1 -> rvalid_o=0 and rdata_o=0 throughout and for LATENCY cycles after release; mem[addr] is unchanged (still 0 with INIT_BY_ZERO=1).
- Latency/streaming: LATENCY=3; write 0xA0+i to addr i for i=0..7, then read addr 0..7 on consecutive cycles -> rvalid_o high 8 consecutive cycles, starting 3 cycles after the first read, with data 0xA0..0xA7 in order.
- Collision: mem[5]=0x11223344; same cycle write 0xAABBCCDD to addr 5 with we_i=4'b0101 and read addr 5 -> COLLISION=0 returns 0x11223344; COLLISION=1 returns 0x11BB33DD; a later read returns 0x11BB33DD in both modes.
- Partial lane: DW=12, BYTE_WRITE=1 (MW=2); write 0xFFF with we_i=2'b10 to zeroed addr 2 -> read returns 0xF00.
- Out of range: DP=5; write 0x55 to addr 6, read addr 6 -> rvalid_o=1 with rdata_o=0; mem[0..4] unchanged.
- Reset mid-flight: LATENCY=4; issue reads at cycles 0-2, pulse rst_i at cycle 2 -> no rvalid_o for those reads; rdata_o=0 after reset; a new read after reset returns correct data with 4-cycle latency.

Source files
------------

// File: rtl/gnrc_sdpram_pipe.sv
// -----------------------------------------------------------------------------
// gnrc_sdpram_pipe
// Single-clock simple dual-port RAM (one write port, one read port) with a
// parametrised read latency, a read-valid strobe and selectable same-address
// collision handling (read-first or per-lane write-first forwarding).
// The storage array is kept free of reset and bypass logic so it maps onto
// block RAM; forwarding is applied after the array read register.
//
// Ports:
//   clk_i     single clock, rising edge
//   rst_i     synchronous active-high reset (valid pipeline and data regs)
//   wen_i     write enable
//   we_i      write mask, one bit per byte lane (or one bit for the word)
//   waddr_i   write address
//   wdata_i   write data
//   ren_i     read request
//   raddr_i   read address
//   rdata_o   read data, valid while rvalid_o=1, held otherwise
//   rvalid_o  one-cycle strobe per accepted read, LATENCY cycles after ren_i
// -----------------------------------------------------------------------------
module gnrc_sdpram_pipe #(
    parameter int DW           = 32,
    parameter int DP           = 512,
    parameter int LATENCY      = 1,
    parameter int COLLISION    = 0,
    parameter int BYTE_WRITE   = 0,
    parameter int INIT_BY_ZERO = 1,
    parameter int AW           = $clog2(DP),
    parameter int MW           = (BYTE_WRITE != 0) ? (DW + 7) / 8 : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wen_i,
    input  logic [MW-1:0] we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          ren_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    output logic          rvalid_o
);

    if (LATENCY < 1 || DP < 2 || DW < 1) begin : g_param_check
        $fatal(1, "gnrc_sdpram_pipe: illegal parameters (need LATENCY>=1, DP>=2, DW>=1)");
    end

    // Depth as an AW+1 bit constant so range checks compare equal widths.
    localparam logic [AW:0] DEPTH = DP[AW:0];

    logic [DW-1:0]      mem_q [DP];
    logic [DW-1:0]      wbit_mask;
    logic               waddr_in;
    logic               raddr_in;
    logic               wr_ok;
    logic               rd_ok;
    logic               collide;
    logic [DW-1:0]      ram_d;
    logic [DW-1:0]      ram_q;
    logic [DW-1:0]      fwd_sel_d;
    logic [DW-1:0]      fwd_sel_q;
    logic [DW-1:0]      fwd_data_q;
    logic [DW-1:0]      s1_data;
    logic [LATENCY-1:0] vld_d;
    logic [LATENCY-1:0] vld_q;

    if (INIT_BY_ZERO != 0) begin : g_init
        initial begin
            for (int i = 0; i < DP; i++) begin
                mem_q[i] = '0;
            end
        end
    end

    // Expand the lane mask to one bit per data bit; a narrow top lane simply
    // covers fewer bits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        wbit_mask = '0;
        for (int b = 0; b < DW; b++) begin
            wbit_mask[b] = we_i[(BYTE_WRITE != 0) ? b / 8 : 0];
        end
    end

    assign waddr_in = ({1'b0, waddr_i} < DEPTH);
    assign raddr_in = ({1'b0, raddr_i} < DEPTH);
    assign wr_ok    = wen_i & ~rst_i & waddr_in;
    assign rd_ok    = ren_i & ~rst_i;
    assign collide  = wr_ok & rd_ok & (waddr_i == raddr_i);

    always_comb begin
        ram_d     = raddr_in ? mem_q[raddr_i] : '0;
        fwd_sel_d = ((COLLISION != 0) && collide) ? wbit_mask : '0;
    end

    // NOTE: the array has no reset; a reset would stop block-RAM inference
    // and contents are meant to survive rst_i.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            for (int b = 0; b < DW; b++) begin
                // NOTE: non-blocking update, so a read of the same address on
                // this edge samples the old word (native read-first array).
                if (wbit_mask[b]) mem_q[waddr_i][b] <= wdata_i[b];
            end
        end
    end

    // First stage: array read register plus the captured forward data and
    // per-bit forward select. Loads only for an accepted read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ram_q      <= '0;
            fwd_data_q <= '0;
            fwd_sel_q  <= '0;
        end else if (rd_ok) begin
            ram_q      <= ram_d;
            fwd_data_q <= wdata_i;
            fwd_sel_q  <= fwd_sel_d;
        end
    end

    assign s1_data = (ram_q & ~fwd_sel_q) | (fwd_data_q & fwd_sel_q);

    // Valid shift register: bit i set means a read sits in stage i+1.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_ok;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) vld_q <= '0;
        else       vld_q <= vld_d;
    end

    assign rvalid_o = vld_q[LATENCY-1];

    if (LATENCY == 1) begin : g_lat1
        assign rdata_o = s1_data;
    end else begin : g_pipe
        logic [DW-1:0] pipe_q [LATENCY-1];

        // Each stage loads only when the data entering it is valid, so the
        // output holds its last value between reads.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
            end else begin
                if (vld_q[0]) pipe_q[0] <= s1_data;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    if (vld_q[i]) pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign rdata_o = pipe_q[LATENCY-2];
    end

endmodule

// File: tb/tb_gnrc_sdpram_pipe.sv
// -----------------------------------------------------------------------------
// tb_gnrc_sdpram_pipe
// Directed bench for gnrc_sdpram_pipe using two instances:
//   u_a: DW=32, DP=12, LATENCY=3, write-first, byte write
//   u_b: DW=12, DP=5,  LATENCY=1, read-first,  byte write (narrow top lane)
// Inputs change #1 after the rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_gnrc_sdpram_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        a_wen;
    logic [3:0]  a_we;
    logic [3:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        a_ren;
    logic [3:0]  a_raddr;
    logic [31:0] a_rdata;
    logic        a_rvalid;

    logic        b_wen;
    logic [1:0]  b_we;
    logic [2:0]  b_waddr;
    logic [11:0] b_wdata;
    logic        b_ren;
    logic [2:0]  b_raddr;
    logic [11:0] b_rdata;
    logic        b_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    gnrc_sdpram_pipe #(
        .DW(32), .DP(12), .LATENCY(3), .COLLISION(1), .BYTE_WRITE(1), .INIT_BY_ZERO(1)
    ) u_a (
        .clk_i(clk), .rst_i(rst),
        .wen_i(a_wen), .we_i(a_we), .waddr_i(a_waddr), .wdata_i(a_wdata),
        .ren_i(a_ren), .raddr_i(a_raddr),
        .rdata_o(a_rdata), .rvalid_o(a_rvalid)
    );

    gnrc_sdpram_pipe #(
        .DW(12), .DP(5), .LATENCY(1), .COLLISION(0), .BYTE_WRITE(1), .INIT_BY_ZERO(1)
    ) u_b (
        .clk_i(clk), .rst_i(rst),
        .wen_i(b_wen), .we_i(b_we), .waddr_i(b_waddr), .wdata_i(b_wdata),
        .ren_i(b_ren), .raddr_i(b_raddr),
        .rdata_o(b_rdata), .rvalid_o(b_rvalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_wen = 1'b0;
        a_ren = 1'b0;
        b_wen = 1'b0;
        b_ren = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        a_wen   = 1'b1;  a_we = 4'hF;  a_waddr = 4'd2;  a_wdata = 32'hFFFF_FFFF;
        a_ren   = 1'b1;  a_raddr = 4'd2;
        b_wen   = 1'b1;  b_we = 2'b11; b_waddr = 3'd2;  b_wdata = 12'hFFF;
        b_ren   = 1'b1;  b_raddr = 3'd2;

        // Reset with both ports active: nothing may come out, nothing written.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_a_vld",  32'(a_rvalid), 32'd0);
            check("rst_a_data", a_rdata,       32'd0);
            check("rst_b_vld",  32'(b_rvalid), 32'd0);
            check("rst_b_data", 32'(b_rdata),  32'd0);
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_a_vld",  32'(a_rvalid), 32'd0);
            check("post_rst_a_data", a_rdata,       32'd0);
            check("post_rst_b_vld",  32'(b_rvalid), 32'd0);
        end

        // Addr 2 must still be zero: the write during reset was ignored.
        a_ren = 1'b1;  a_raddr = 4'd2;
        b_ren = 1'b1;  b_raddr = 3'd2;
        tick();
        idle();
        check("rd2_b_vld",  32'(b_rvalid), 32'd1);
        check("rd2_b_data", 32'(b_rdata),  32'd0);
        check("rd2_a_early", 32'(a_rvalid), 32'd0);
        tick();
        check("rd2_b_vld_drop", 32'(b_rvalid), 32'd0);
        check("rd2_a_early2",   32'(a_rvalid), 32'd0);
        tick();
        check("rd2_a_vld",  32'(a_rvalid), 32'd1);
        check("rd2_a_data", a_rdata,       32'd0);

        // Streaming on u_a: fill 0..7, then read back-to-back.
        for (int i = 0; i < 8; i++) begin
            a_wen = 1'b1;  a_we = 4'hF;  a_waddr = 4'(i);  a_wdata = 32'hA0 + 32'(i);
            tick();
        end
        a_wen = 1'b0;
        for (int i = 0; i < 11; i++) begin
            a_ren   = (i < 8);
            a_raddr = 4'(i);
            tick();
            check("stream_vld", 32'(a_rvalid), 32'(i >= 2 && i <= 9));
            if (i >= 2 && i <= 9) check("stream_data", a_rdata, 32'hA0 + 32'(i - 2));
        end
        a_ren = 1'b0;
        tick();
        check("stream_hold", a_rdata, 32'hA7);

        // Write-first collision on u_a with lanes 0 and 2 written.
        a_wen = 1'b1;  a_we = 4'hF;  a_waddr = 4'd5;  a_wdata = 32'h1122_3344;
        tick();
        a_we = 4'b0101;  a_wdata = 32'hAABB_CCDD;
        a_ren = 1'b1;  a_raddr = 4'd5;
        tick();
        idle();
        tick();
        tick();
        check("coll_a_vld",  32'(a_rvalid), 32'd1);
        check("coll_a_data", a_rdata,       32'h11BB_33DD);

        // A write following an accepted read must not alter that read.
        a_ren = 1'b1;  a_raddr = 4'd5;
        tick();
        a_ren = 1'b0;
        a_wen = 1'b1;  a_we = 4'hF;  a_waddr = 4'd5;  a_wdata = 32'hCAFE_F00D;
        tick();
        a_wen = 1'b0;
        tick();
        check("after_wr_vld",  32'(a_rvalid), 32'd1);
        check("after_wr_data", a_rdata,       32'h11BB_33DD);
        a_ren = 1'b1;
        tick();
        a_ren = 1'b0;
        tick();
        tick();
        check("new_word_data", a_rdata, 32'hCAFE_F00D);

        // Read-first collision on u_b.
        b_wen = 1'b1;  b_we = 2'b11;  b_waddr = 3'd3;  b_wdata = 12'h344;
        tick();
        b_we = 2'b01;  b_wdata = 12'hABC;
        b_ren = 1'b1;  b_raddr = 3'd3;
        tick();
        idle();
        check("coll_b_vld",  32'(b_rvalid), 32'd1);
        check("coll_b_data", 32'(b_rdata),  32'h344);
        b_ren = 1'b1;
        tick();
        b_ren = 1'b0;
        check("coll_b_later", 32'(b_rdata), 32'h3BC);

        // Narrow top lane: only bits 11:8 written.
        b_wen = 1'b1;  b_we = 2'b10;  b_waddr = 3'd2;  b_wdata = 12'hFFF;
        tick();
        b_wen = 1'b0;
        b_ren = 1'b1;  b_raddr = 3'd2;
        tick();
        b_ren = 1'b0;
        check("part_lane", 32'(b_rdata), 32'hF00);

        // Reset while reads are in flight on u_a.
        a_ren = 1'b1;  a_raddr = 4'd0;
        tick();
        a_raddr = 4'd1;
        tick();
        check("mid_vld_pre", 32'(a_rvalid), 32'd0);
        a_raddr = 4'd2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_ren = 1'b0;
        check("mid_rst_vld",    32'(a_rvalid), 32'd0);
        check("mid_rst_a_data", a_rdata,       32'd0);
        check("mid_rst_b_data", 32'(b_rdata),  32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_drop_vld",  32'(a_rvalid), 32'd0);
            check("mid_drop_data", a_rdata,       32'd0);
        end
        a_ren = 1'b1;  a_raddr = 4'd3;
        tick();
        a_ren = 1'b0;
        check("mid_new_lat0", 32'(a_rvalid), 32'd0);
        tick();
        check("mid_new_lat1", 32'(a_rvalid), 32'd0);
        tick();
        check("mid_new_vld",  32'(a_rvalid), 32'd1);
        check("mid_new_data", a_rdata,       32'hA3);

        // Out-of-range addresses on u_b (DP=5) and u_a (DP=12).
        b_wen = 1'b1;  b_we = 2'b11;  b_waddr = 3'd6;  b_wdata = 12'h055;
        tick();
        b_wen = 1'b0;
        b_ren = 1'b1;  b_raddr = 3'd3;
        tick();
        check("oor_b_pre", 32'(b_rdata), 32'h3BC);
        b_raddr = 3'd6;
        tick();
        check("oor_b_vld",  32'(b_rvalid), 32'd1);
        check("oor_b_data", 32'(b_rdata),  32'd0);
        b_raddr = 3'd4;
        tick();
        check("oor_b_mem4", 32'(b_rdata), 32'd0);
        b_raddr = 3'd1;
        tick();
        check("oor_b_mem1", 32'(b_rdata), 32'd0);
        b_raddr = 3'd0;
        tick();
        b_ren = 1'b0;
        check("oor_b_mem0", 32'(b_rdata), 32'd0);

        a_wen = 1'b1;  a_we = 4'hF;  a_waddr = 4'd13;  a_wdata = 32'h0000_DEAD;
        tick();
        a_wen = 1'b0;
        a_ren = 1'b1;  a_raddr = 4'd13;
        tick();
        a_ren = 1'b0;
        tick();
        tick();
        check("oor_a_vld",  32'(a_rvalid), 32'd1);
        check("oor_a_data", a_rdata,       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
